// File: rtl/jk_drive_checker.sv
// rtl/jk_drive_checker.sv - drives an external JK flip-flop through a pattern and checks its response
module jk_drive_checker #(
    parameter int N  = 8,
    parameter int CW = 3
) (
    input  logic          c,
    input  logic          reset,
    input  logic          start,
    input  logic [N-1:0]  pattern,
    input  logic [CW-1:0] len_m1,
    input  logic          mode,
    input  logic          q_obs,
    input  logic          qn_obs,
    output logic          j,
    output logic          k,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [CW:0]   err_count,
    output logic [CW-1:0] err_idx
);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, FIN} state_t;

    localparam logic [CW:0]   ERR_MAX = '1;
    localparam logic [CW-1:0] LEN_MAX = CW'(N - 1);

    state_t        state;
    logic [N-1:0]  pat_l;
    logic [CW-1:0] len_l;
    logic [CW-1:0] step;
    logic          mode_l;
    logic          q_exp;
    logic          tgt;
    logic          mismatch;

    assign tgt      = pat_l[step];
    assign mismatch = (q_obs != tgt) || (qn_obs != ~q_obs);

    // Excitation is only presented during DRIVE; reset blanks it immediately.
    always_comb begin
        j = 1'b0;
        k = 1'b0;
        if (state == DRIVE && !reset && tgt != q_exp) begin
            if (mode_l) begin
                j = 1'b1;
                k = 1'b1;
            end else begin
                j = tgt;
                k = ~tgt;
            end
        end
    end

    always_ff @(posedge c) begin
        if (reset) begin
            state     <= IDLE;
            pat_l     <= '0;
            len_l     <= '0;
            step      <= '0;
            mode_l    <= 1'b0;
            q_exp     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            err_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        pat_l     <= pattern;
                        len_l     <= (len_m1 > LEN_MAX) ? LEN_MAX : len_m1;
                        mode_l    <= mode;
                        q_exp     <= q_obs;
                        step      <= '0;
                        err_count <= '0;
                        err_idx   <= '0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        state     <= DRIVE;
                    end
                end
                DRIVE: state <= CHECK;
                CHECK: begin
                    if (mismatch) begin
                        if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
                        if (err_count == '0) err_idx <= step;
                    end
                    // Track the intended value so one bad sample does not poison later steps.
                    q_exp <= tgt;
                    if (step == len_l) begin
                        done  <= 1'b1;
                        pass  <= !mismatch && (err_count == '0);
                        state <= FIN;
                    end else begin
                        step  <= step + 1'b1;
                        state <= DRIVE;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jk_drive_checker.sv
// tb/tb_jk_drive_checker.sv - randomized self-checking bench with an ideal JK flip-flop model
module tb_jk_drive_checker;

    localparam int N  = 8;
    localparam int CW = 3;

    logic          c = 1'b0;
    logic          reset, start, mode;
    logic [N-1:0]  pattern;
    logic [CW-1:0] len_m1;
    logic          q_obs, qn_obs;
    logic          j, k, busy, done, pass;
    logic [CW:0]   err_count;
    logic [CW-1:0] err_idx;

    logic ffq, ff_clr, fault_on, fault_q, fault_qn;
    int   checks = 0;
    int   errors = 0;

    jk_drive_checker #(.N(N), .CW(CW)) dut (
        .c(c), .reset(reset), .start(start), .pattern(pattern), .len_m1(len_m1),
        .mode(mode), .q_obs(q_obs), .qn_obs(qn_obs), .j(j), .k(k), .busy(busy),
        .done(done), .pass(pass), .err_count(err_count), .err_idx(err_idx)
    );

    always #5 c = ~c;

    // Ideal external JK flip-flop; faults only corrupt what the checker observes.
    always @(posedge c) begin
        if (ff_clr)      ffq <= 1'b0;
        else if (j && k) ffq <= ~ffq;
        else if (j)      ffq <= 1'b1;
        else if (k)      ffq <= 1'b0;
    end
    assign q_obs  = fault_on ? fault_q  : ffq;
    assign qn_obs = fault_on ? fault_qn : ~ffq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered and left #1 after a rising edge with the DUT idle (unless reset aborts).
    task automatic run_seq(input logic [N-1:0] pat, input int len, input bit md,
                           input int fstep, input int fkind, input int rst_at,
                           input int extra_start_at,
                           output logic [15:0] trace, output int done_at);
        int  lc, last, s, errs, idx;
        bit  qm, t, ej, ek;
        pattern = pat;
        len_m1  = CW'(len);
        mode    = md;
        start   = 1'b1;
        qm      = q_obs;
        errs    = 0;
        idx     = 0;
        trace   = '0;
        done_at = -1;
        lc      = (len > N - 1) ? N - 1 : len;
        last    = 2 * (lc + 1) + 1;
        @(posedge c); #1;
        for (int n = 1; n <= last; n++) begin
            pattern  = N'($urandom);
            len_m1   = CW'($urandom);
            mode     = 1'($urandom);
            start    = (n == extra_start_at);
            s        = (n - 1) / 2;
            t        = pat[s];
            fault_on = (n % 2 == 0) && (s == fstep) && (n < last);
            fault_q  = (fkind == 0) ? 1'b0 : ~t;
            fault_qn = (fkind == 0) ? 1'b0 : t;
            reset    = (n == rst_at);
            @(negedge c);
            if (n % 2 == 1 && n < last) begin
                ej = 0; ek = 0;
                if (t != qm && !reset) begin
                    ej = md ? 1'b1 : t;
                    ek = md ? 1'b1 : ~t;
                end
                chk("j_drive", j, ej);
                chk("k_drive", k, ek);
                trace = {trace[13:0], j, k};
            end else begin
                chk("j_idle", j, 0);
                chk("k_idle", k, 0);
            end
            chk("busy_run", busy, 1);
            chk("done_run", done, n == last);
            if (done) done_at = n - 1;
            if (n == last) begin
                chk("pass_fin", pass, errs == 0);
                chk("errcnt_fin", err_count, errs);
                chk("erridx_fin", err_idx, idx);
            end
            if (n % 2 == 0 && n < last) begin
                if (fault_on) begin
                    errs++;
                    if (errs == 1) idx = s;
                end
                qm = t;
            end
            if (n == rst_at) begin
                @(posedge c); #1;
                reset    = 1'b0;
                start    = 1'b0;
                fault_on = 1'b0;
                @(negedge c);
                chk("rst_busy", busy, 0);
                chk("rst_j", j, 0);
                chk("rst_k", k, 0);
                chk("rst_pass", pass, 0);
                chk("rst_errcnt", err_count, 0);
                chk("rst_erridx", err_idx, 0);
                for (int m = 0; m < 4; m++) begin
                    chk("rst_no_done", done, 0);
                    @(negedge c);
                end
                @(posedge c); #1;
                return;
            end
            @(posedge c); #1;
        end
        start    = 1'b0;
        fault_on = 1'b0;
        @(negedge c);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("hold_pass", pass, errs == 0);
        chk("hold_errcnt", err_count, errs);
        chk("hold_erridx", err_idx, idx);
        @(posedge c); #1;
    endtask

    logic [15:0] tr;
    int          da;

    initial begin
        reset = 1'b1; ff_clr = 1'b1; start = 1'b0; fault_on = 1'b0;
        fault_q = 1'b0; fault_qn = 1'b0; pattern = '0; len_m1 = '0; mode = 1'b0;
        repeat (2) @(posedge c);
        #1 reset = 1'b0; ff_clr = 1'b0;
        @(negedge c);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_pass", pass, 0);
        chk("reset_errcnt", err_count, 0);
        chk("reset_erridx", err_idx, 0);
        chk("reset_jk", {j, k}, 0);
        @(posedge c); #1;

        run_seq(8'b0110_1010, 7, 1'b0, -1, 0, -1, -1, tr, da);
        chk("lit_trace_m0", tr, 16'b0010_0110_0110_0001);
        chk("lit_done_at", da, 16);
        chk("lit_pass_m0", pass, 1);

        run_seq(8'b0110_1010, 7, 1'b1, -1, 0, -1, -1, tr, da);
        chk("lit_trace_m1", tr, 16'b0011_1111_1111_0011);
        chk("lit_pass_m1", pass, 1);

        run_seq(8'b0110_1010, 7, 1'b0, 3, 0, -1, -1, tr, da);
        chk("lit_fault_cnt", err_count, 1);
        chk("lit_fault_idx", err_idx, 3);
        chk("lit_fault_pass", pass, 0);

        run_seq(8'b0110_1010, 7, 1'b0, -1, 0, 6, -1, tr, da);
        run_seq(8'b0110_1010, 7, 1'b0, -1, 0, -1, -1, tr, da);
        chk("lit_after_rst_done", da, 16);

        run_seq({7'b0, ~q_obs}, 0, 1'b0, -1, 0, -1, 1, tr, da);
        chk("lit_len0_done_at", da, 2);
        chk("lit_len0_pass", pass, 1);

        reset = 1'b1; start = 1'b1;
        @(posedge c); #1;
        reset = 1'b0; start = 1'b0;
        @(negedge c);
        chk("start_in_reset_busy", busy, 0);
        @(posedge c); #1;

        for (int it = 0; it < 60; it++) begin
            int fs, rs, xs;
            fs = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, N - 1));
            rs = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 10)) : -1;
            xs = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2 * N + 1)) : -1;
            run_seq(N'($urandom), int'($urandom_range(0, N - 1)), 1'($urandom), fs,
                    int'($urandom_range(0, 1)), rs, xs, tr, da);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
